// File: rtl/ii_bank_scheduler.sv
// Ping-pong bank scheduler for the two integral-image RAM banks.
// Optional drop/short counters are built only when II_SCHED_DROP_CNT_EN is defined.
module ii_bank_scheduler #(
  parameter int FRAME_WORDS = 19200,
  parameter int ADDR_W      = 15,
  parameter int CNT_W       = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] ii_address,
  input  logic              cap_done,
  input  logic [ADDR_W-1:0] det_addr,
  input  logic              det_done,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_waddr,
  output logic [ADDR_W:0]   mem_raddr,
  output logic              det_start,
  output logic              det_busy,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  short_cnt,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_FILL      = 2'd1;
  localparam logic [1:0] S_FILL_BUSY = 2'd2;

  localparam int WC_W = $clog2(FRAME_WORDS + 2);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(FRAME_WORDS);
  localparam logic [WC_W-1:0] WC_SAT  = WC_W'(FRAME_WORDS + 1);

  logic [1:0]       state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             det_start_q, det_start_d;
  logic [WC_W-1:0]  wr_cnt_q, wr_cnt_d, wr_cnt_eff;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             word_ok, frame_ok, handoff;

  // Handshake: det_start is a one-cycle tick once rd_bank holds a whole frame;
  // the detector keeps that bank (det_busy) until it returns a one-cycle det_done.
  always_comb begin
    word_ok    = we && (state_q != S_IDLE);
    wr_cnt_eff = (word_ok && (wr_cnt_q != WC_SAT)) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    frame_ok   = cap_done && (state_q != S_IDLE) && (wr_cnt_eff == WC_FULL);
    handoff    = frame_ok && ((state_q == S_FILL) || ((state_q == S_FILL_BUSY) && det_done));

    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    det_start_d = handoff;
    wr_cnt_d    = cap_done ? '0 : wr_cnt_eff;
    frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, handoff};

    if (handoff) begin
      rd_bank_d = wr_bank_q;
      wr_bank_d = ~wr_bank_q;
    end

    case (state_q)
      S_IDLE:      if (cap_done) state_d = S_FILL;
      S_FILL:      if (handoff) state_d = S_FILL_BUSY;
      S_FILL_BUSY: if (det_done && !frame_ok) state_d = S_FILL;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      det_start_q <= 1'b0;
      wr_cnt_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      det_start_q <= det_start_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef II_SCHED_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] short_cnt_q, short_cnt_d;
  logic             drop_ev, short_ev;

  always_comb begin
    drop_ev     = frame_ok && (state_q == S_FILL_BUSY) && !det_done;
    short_ev    = cap_done && (state_q != S_IDLE) && !frame_ok;
    drop_cnt_d  = drop_cnt_q + {{(CNT_W-1){1'b0}}, drop_ev};
    short_cnt_d = short_cnt_q + {{(CNT_W-1){1'b0}}, short_ev};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q  <= '0;
      short_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign short_cnt = short_cnt_q;
`else
  assign drop_cnt  = '0;
  assign short_cnt = '0;
`endif

  assign mem_we    = word_ok;
  assign mem_waddr = {wr_bank_q, ii_address};
  assign mem_raddr = {rd_bank_q, det_addr};
  assign det_start = det_start_q;
  assign det_busy  = (state_q == S_FILL_BUSY);
  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign frame_cnt = frame_cnt_q;
  assign state_dbg = state_q;

endmodule
